// File: rtl/isa_trk_pkg.sv
// Shared types and constants for the ISA pipeline tracker.
// PCs are stored at XLEN_MAX width so one stage type serves every XLEN build.
package isa_trk_pkg;

  localparam int XLEN_MAX = 64;

  localparam logic [XLEN_MAX-1:0] PC_INIT  = XLEN_MAX'(32'h0000_0200);
  localparam logic [31:0]         NOP_INSN = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN_MAX-1:0] pc;
    logic [31:0]         insn;
    logic                valid;
  } stage_t;

  localparam stage_t STAGE_RST = '{pc: PC_INIT, insn: NOP_INSN, valid: 1'b0};

  // Priority: kill > stall > advance. A held stage keeps its own contents,
  // and the stage just behind the stall boundary takes a bubble.
  function automatic stage_t stage_next(input stage_t cur, input stage_t src,
                                        input logic hold, input logic bubble,
                                        input logic killed);
    stage_t n;
    n = hold ? cur : src;
    if (killed || bubble) n.valid = 1'b0;
    return n;
  endfunction

endpackage

// File: rtl/isa_shadow_rf.sv
// Golden shadow register file: 31 x XLEN entries, x0 hard-wired to zero.
// Compiled only with ISA_SHADOW_RF_EN defined; reads return pre-write contents.
`ifdef ISA_SHADOW_RF_EN
module isa_shadow_rf #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [4:0]      rd,
  input  logic [XLEN-1:0] wdata,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2
);

  logic [XLEN-1:0] regs [31:1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < 32; i++) regs[i] <= '0;
    end else if (we && (rd != 5'd0)) begin
      regs[rd] <= wdata;
    end
  end

  always_comb begin
    rdata1 = (rs1 == 5'd0) ? '0 : regs[rs1];
    rdata2 = (rs2 == 5'd0) ? '0 : regs[rs2];
  end

endmodule
`endif

// File: rtl/isa_pipe_tracker.sv
// Pipeline follower shadowing PC/encoding/valid per stage and emitting retirement records.
// Define ISA_SHADOW_RF_EN to add the golden shadow register file and its rf_*/rs* ports.
module isa_pipe_tracker
  import isa_trk_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int STAGES = 5,
  parameter int FRONT  = 2,
  parameter int KILL   = 3,
  parameter int SEQ_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [XLEN-1:0]        if_pc_i,
  input  logic [31:0]            if_insn_i,
  input  logic                   if_bubble_i,
  input  logic                   stall_i,
  input  logic                   flush_i,
  input  logic                   exc_i,
  output logic [STAGES-1:0]      stage_valid_o,
  output logic [STAGES*XLEN-1:0] stage_pc_o,
  output logic                   ret_valid_o,
  output logic [XLEN-1:0]        ret_pc_o,
  output logic [31:0]            ret_insn_o,
  output logic [SEQ_W-1:0]       ret_seq_o
`ifdef ISA_SHADOW_RF_EN
  ,
  input  logic                   rf_we_i,
  input  logic [4:0]             rf_rd_i,
  input  logic [XLEN-1:0]        rf_wdata_i,
  input  logic [4:0]             rs1_i,
  input  logic [4:0]             rs2_i,
  output logic [XLEN-1:0]        rs1_o,
  output logic [XLEN-1:0]        rs2_o
`endif
);

  stage_t st     [STAGES];
  stage_t st_nxt [STAGES];
  stage_t fetch;
  logic   kill;

  assign kill = flush_i | exc_i;

  // Fetch PCs are forced to word alignment on entry.
  always_comb begin
    fetch.pc    = XLEN_MAX'(if_pc_i & ~XLEN'(3));
    fetch.insn  = if_insn_i;
    fetch.valid = ~if_bubble_i;
  end

  always_comb begin
    st_nxt[0] = stage_next(st[0], fetch, stall_i, 1'b0, kill);
    for (int i = 1; i < STAGES; i++) begin
      st_nxt[i] = stage_next(st[i], st[i-1],
                             (i < FRONT) && stall_i,
                             (i == FRONT) && stall_i,
                             (i < KILL) && kill);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) st[i] <= STAGE_RST;
      ret_seq_o <= '0;
    end else begin
      for (int i = 0; i < STAGES; i++) st[i] <= st_nxt[i];
      if (st[STAGES-1].valid) ret_seq_o <= ret_seq_o + SEQ_W'(1);
    end
  end

  always_comb begin
    for (int i = 0; i < STAGES; i++) begin
      stage_valid_o[i]           = st[i].valid;
      stage_pc_o[i*XLEN +: XLEN] = st[i].pc[XLEN-1:0];
    end
    ret_valid_o = st[STAGES-1].valid;
    ret_pc_o    = st[STAGES-1].pc[XLEN-1:0];
    ret_insn_o  = st[STAGES-1].insn;
  end

  // PC bits above XLEN are always zero; fold them away explicitly.
  if (XLEN < XLEN_MAX) begin : g_pc_hi
    logic unused_pc_hi;
    always_comb begin
      unused_pc_hi = 1'b0;
      for (int i = 0; i < STAGES; i++) unused_pc_hi = unused_pc_hi | (|st[i].pc[XLEN_MAX-1:XLEN]);
    end
  end

`ifdef ISA_SHADOW_RF_EN
  isa_shadow_rf #(
    .XLEN (XLEN)
  ) u_shadow_rf (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (rf_we_i),
    .rd     (rf_rd_i),
    .wdata  (rf_wdata_i),
    .rs1    (rs1_i),
    .rs2    (rs2_i),
    .rdata1 (rs1_o),
    .rdata2 (rs2_o)
  );
`endif

endmodule

// File: tb/tb_isa_pipe_tracker.sv
// Directed, table-driven bench for isa_pipe_tracker (STAGES=5, FRONT=2, KILL=3, SEQ_W=4).
// Shadow RF sequences are included when ISA_SHADOW_RF_EN is defined.
module tb_isa_pipe_tracker;

  localparam int XLEN   = 32;
  localparam int STAGES = 5;
  localparam int SEQ_W  = 4;

  localparam logic [31:0] I_NOP = 32'h0000_0013;
  localparam logic [31:0] I_A  = 32'h0010_0093;
  localparam logic [31:0] I_B  = 32'h0020_0113;
  localparam logic [31:0] I_C  = 32'h0030_8193;
  localparam logic [31:0] I_D  = 32'h0041_0213;
  localparam logic [31:0] I_E  = 32'h0051_8293;
  localparam logic [31:0] I_F  = 32'h0062_0313;
  localparam logic [31:0] I_G0 = 32'h0072_8393;
  localparam logic [31:0] I_G1 = 32'h0083_0413;
  localparam logic [31:0] I_G2 = 32'h0093_8493;
  localparam logic [31:0] I_G3 = 32'h00A4_0513;
  localparam logic [31:0] I_G4 = 32'h00B4_8593;
  localparam logic [31:0] I_H0 = 32'h00C5_0613;
  localparam logic [31:0] I_H1 = 32'h00D5_8693;
  localparam logic [31:0] I_H2 = 32'h00E6_0713;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [XLEN-1:0]        if_pc_i;
  logic [31:0]            if_insn_i;
  logic                   if_bubble_i;
  logic                   stall_i;
  logic                   flush_i;
  logic                   exc_i;
  logic [STAGES-1:0]      stage_valid_o;
  logic [STAGES*XLEN-1:0] stage_pc_o;
  logic                   ret_valid_o;
  logic [XLEN-1:0]        ret_pc_o;
  logic [31:0]            ret_insn_o;
  logic [SEQ_W-1:0]       ret_seq_o;
`ifdef ISA_SHADOW_RF_EN
  logic                   rf_we_i;
  logic [4:0]             rf_rd_i;
  logic [XLEN-1:0]        rf_wdata_i;
  logic [4:0]             rs1_i;
  logic [4:0]             rs2_i;
  logic [XLEN-1:0]        rs1_o;
  logic [XLEN-1:0]        rs2_o;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  isa_pipe_tracker #(
    .XLEN   (XLEN),
    .STAGES (STAGES),
    .FRONT  (2),
    .KILL   (3),
    .SEQ_W  (SEQ_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .if_pc_i       (if_pc_i),
    .if_insn_i     (if_insn_i),
    .if_bubble_i   (if_bubble_i),
    .stall_i       (stall_i),
    .flush_i       (flush_i),
    .exc_i         (exc_i),
    .stage_valid_o (stage_valid_o),
    .stage_pc_o    (stage_pc_o),
    .ret_valid_o   (ret_valid_o),
    .ret_pc_o      (ret_pc_o),
    .ret_insn_o    (ret_insn_o),
    .ret_seq_o     (ret_seq_o)
`ifdef ISA_SHADOW_RF_EN
    ,
    .rf_we_i       (rf_we_i),
    .rf_rd_i       (rf_rd_i),
    .rf_wdata_i    (rf_wdata_i),
    .rs1_i         (rs1_i),
    .rs2_i         (rs2_i),
    .rs1_o         (rs1_o),
    .rs2_o         (rs2_o)
`endif
  );

  typedef struct {
    logic        bubble;
    logic [31:0] pc;
    logic [31:0] insn;
    logic        stall;
    logic        flush;
    logic        exc;
    logic        exp_rv;
    logic [31:0] exp_rpc;
    logic [31:0] exp_rinsn;
    logic [3:0]  exp_seq;
    logic [31:0] exp_s0pc;
    logic [4:0]  exp_mask;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic bub, input logic [31:0] pc, input logic [31:0] insn,
                              input logic st, input logic fl, input logic ex,
                              input logic rv, input logic [31:0] rpc, input logic [31:0] rinsn,
                              input logic [3:0] seq, input logic [31:0] s0pc, input logic [4:0] mask);
    vec_t v;
    v.bubble = bub; v.pc = pc; v.insn = insn; v.stall = st; v.flush = fl; v.exc = ex;
    v.exp_rv = rv; v.exp_rpc = rpc; v.exp_rinsn = rinsn; v.exp_seq = seq;
    v.exp_s0pc = s0pc; v.exp_mask = mask;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    if_bubble_i = v.bubble;
    if_pc_i     = v.pc;
    if_insn_i   = v.insn;
    stall_i     = v.stall;
    flush_i     = v.flush;
    exc_i       = v.exc;
  endtask

  task automatic driveInsn(input logic [31:0] pc, input logic [31:0] insn);
    if_bubble_i = 1'b0;
    if_pc_i     = pc;
    if_insn_i   = insn;
    stall_i     = 1'b0;
    flush_i     = 1'b0;
    exc_i       = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // bub pc insn stall flush exc | ret_valid ret_pc ret_insn seq s0_pc valid_mask
    vecs.push_back(mk(0, 32'h204, I_A,   0, 0, 0, 0, 32'h200, I_NOP, 0, 32'h204, 5'b00001));
    vecs.push_back(mk(0, 32'h207, I_B,   0, 0, 0, 0, 32'h200, I_NOP, 0, 32'h204, 5'b00011));
    vecs.push_back(mk(0, 32'h20C, I_C,   0, 0, 0, 0, 32'h200, I_NOP, 0, 32'h20C, 5'b00111));
    vecs.push_back(mk(1, 32'h210, I_NOP, 0, 0, 0, 0, 32'h200, I_NOP, 0, 32'h210, 5'b01110));
    vecs.push_back(mk(1, 32'h214, I_NOP, 0, 0, 0, 1, 32'h204, I_A,   0, 32'h214, 5'b11100));
    vecs.push_back(mk(1, 32'h218, I_NOP, 0, 0, 0, 1, 32'h204, I_B,   1, 32'h218, 5'b11000));
    vecs.push_back(mk(1, 32'h21C, I_NOP, 0, 0, 0, 1, 32'h20C, I_C,   2, 32'h21C, 5'b10000));
    vecs.push_back(mk(1, 32'h220, I_NOP, 0, 0, 0, 0, 32'h210, I_NOP, 3, 32'h220, 5'b00000));
    vecs.push_back(mk(0, 32'h300, I_D,   0, 0, 0, 0, 32'h214, I_NOP, 3, 32'h300, 5'b00001));
    vecs.push_back(mk(0, 32'h304, I_E,   0, 0, 0, 0, 32'h218, I_NOP, 3, 32'h304, 5'b00011));
    vecs.push_back(mk(0, 32'h308, I_F,   1, 0, 0, 0, 32'h21C, I_NOP, 3, 32'h304, 5'b00011));
    vecs.push_back(mk(0, 32'h308, I_F,   1, 0, 0, 0, 32'h220, I_NOP, 3, 32'h304, 5'b00011));
    vecs.push_back(mk(0, 32'h308, I_F,   1, 0, 0, 0, 32'h300, I_D,   3, 32'h304, 5'b00011));
    vecs.push_back(mk(0, 32'h308, I_F,   0, 0, 0, 0, 32'h300, I_D,   3, 32'h308, 5'b00111));
    vecs.push_back(mk(1, 32'h30C, I_NOP, 0, 0, 0, 0, 32'h300, I_D,   3, 32'h30C, 5'b01110));
    vecs.push_back(mk(1, 32'h310, I_NOP, 0, 0, 0, 1, 32'h300, I_D,   3, 32'h310, 5'b11100));
    vecs.push_back(mk(1, 32'h314, I_NOP, 0, 0, 0, 1, 32'h304, I_E,   4, 32'h314, 5'b11000));
    vecs.push_back(mk(1, 32'h318, I_NOP, 0, 0, 0, 1, 32'h308, I_F,   5, 32'h318, 5'b10000));
    vecs.push_back(mk(1, 32'h31C, I_NOP, 0, 0, 0, 0, 32'h30C, I_NOP, 6, 32'h31C, 5'b00000));
    vecs.push_back(mk(0, 32'h400, I_G0,  0, 0, 0, 0, 32'h310, I_NOP, 6, 32'h400, 5'b00001));
    vecs.push_back(mk(0, 32'h404, I_G1,  0, 0, 0, 0, 32'h314, I_NOP, 6, 32'h404, 5'b00011));
    vecs.push_back(mk(0, 32'h408, I_G2,  0, 0, 0, 0, 32'h318, I_NOP, 6, 32'h408, 5'b00111));
    vecs.push_back(mk(0, 32'h40C, I_G3,  0, 0, 0, 0, 32'h31C, I_NOP, 6, 32'h40C, 5'b01111));
    vecs.push_back(mk(0, 32'h410, I_G4,  0, 1, 0, 1, 32'h400, I_G0,  6, 32'h410, 5'b11000));
    vecs.push_back(mk(1, 32'h414, I_NOP, 0, 0, 0, 1, 32'h404, I_G1,  7, 32'h414, 5'b10000));
    vecs.push_back(mk(1, 32'h418, I_NOP, 0, 0, 0, 0, 32'h408, I_G2,  8, 32'h418, 5'b00000));
    vecs.push_back(mk(1, 32'h41C, I_NOP, 0, 0, 0, 0, 32'h40C, I_G3,  8, 32'h41C, 5'b00000));
    vecs.push_back(mk(1, 32'h420, I_NOP, 0, 0, 0, 0, 32'h410, I_G4,  8, 32'h420, 5'b00000));
    vecs.push_back(mk(0, 32'h500, I_H0,  0, 0, 0, 0, 32'h414, I_NOP, 8, 32'h500, 5'b00001));
    vecs.push_back(mk(0, 32'h504, I_H1,  0, 0, 0, 0, 32'h418, I_NOP, 8, 32'h504, 5'b00011));
    vecs.push_back(mk(0, 32'h508, I_H2,  1, 0, 1, 0, 32'h41C, I_NOP, 8, 32'h504, 5'b00000));
    vecs.push_back(mk(1, 32'h50C, I_NOP, 0, 0, 0, 0, 32'h420, I_NOP, 8, 32'h50C, 5'b00000));
    vecs.push_back(mk(1, 32'h510, I_NOP, 0, 0, 0, 0, 32'h500, I_H0,  8, 32'h510, 5'b00000));

    rst_n = 1'b0;
    driveInsn(32'h0, I_NOP);
    if_bubble_i = 1'b1;
`ifdef ISA_SHADOW_RF_EN
    rf_we_i = 1'b0; rf_rd_i = 5'd0; rf_wdata_i = '0; rs1_i = 5'd0; rs2_i = 5'd0;
`endif
    repeat (2) @(posedge clk);
    #1;

    checkOutput("reset stage_valid", 64'(stage_valid_o), 64'h0);
    for (int i = 0; i < STAGES; i++)
      checkOutput($sformatf("reset stage%0d_pc", i), 64'(stage_pc_o[i*XLEN +: XLEN]), 64'h200);
    checkOutput("reset ret_valid", 64'(ret_valid_o), 64'h0);
    checkOutput("reset ret_insn", 64'(ret_insn_o), 64'(I_NOP));
    checkOutput("reset ret_seq", 64'(ret_seq_o), 64'h0);

    rst_n = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      @(posedge clk);
      #1;
      checkOutput($sformatf("v%0d ret_valid", i), 64'(ret_valid_o), 64'(vecs[i].exp_rv));
      checkOutput($sformatf("v%0d ret_pc", i), 64'(ret_pc_o), 64'(vecs[i].exp_rpc));
      checkOutput($sformatf("v%0d ret_insn", i), 64'(ret_insn_o), 64'(vecs[i].exp_rinsn));
      checkOutput($sformatf("v%0d ret_seq", i), 64'(ret_seq_o), 64'(vecs[i].exp_seq));
      checkOutput($sformatf("v%0d stage0_pc", i), 64'(stage_pc_o[XLEN-1:0]), 64'(vecs[i].exp_s0pc));
      checkOutput($sformatf("v%0d stage_valid", i), 64'(stage_valid_o), 64'(vecs[i].exp_mask));
    end

    // Asynchronous reset in mid-cycle with live instructions and a nonzero counter.
    for (int k = 0; k < 3; k++) begin
      driveInsn(32'h700 + 32'(4 * k), I_A);
      @(posedge clk);
      #1;
    end
    checkOutput("pre-reset stage_valid", 64'(stage_valid_o), 64'h7);
    rst_n = 1'b0;
    #2;
    checkOutput("async reset stage_valid", 64'(stage_valid_o), 64'h0);
    checkOutput("async reset ret_seq", 64'(ret_seq_o), 64'h0);
    checkOutput("async reset stage0_pc", 64'(stage_pc_o[XLEN-1:0]), 64'h200);
    checkOutput("async reset stage1_insn_ret", 64'(ret_insn_o), 64'(I_NOP));
    rst_n = 1'b1;

    // 17 back-to-back retires across the 4-bit counter wrap.
    for (int k = 0; k < 21; k++) begin
      driveInsn(32'h600 + 32'(4 * k), I_B);
      @(posedge clk);
      #1;
      checkOutput($sformatf("wrap%0d ret_valid", k), 64'(ret_valid_o), (k >= 4) ? 64'h1 : 64'h0);
      checkOutput($sformatf("wrap%0d ret_pc", k), 64'(ret_pc_o),
                  (k >= 4) ? 64'(32'h600 + 32'(4 * (k - 4))) : 64'h200);
      checkOutput($sformatf("wrap%0d ret_seq", k), 64'(ret_seq_o),
                  (k >= 4) ? 64'((k - 4) % 16) : 64'h0);
    end

`ifdef ISA_SHADOW_RF_EN
    if_bubble_i = 1'b1;
    rf_we_i = 1'b1; rf_rd_i = 5'd5; rf_wdata_i = 32'hDEAD_BEEF; rs1_i = 5'd5; rs2_i = 5'd5;
    #1;
    checkOutput("rf same-cycle rs1", 64'(rs1_o), 64'h0);
    checkOutput("rf same-cycle rs2", 64'(rs2_o), 64'h0);
    @(posedge clk);
    #1;
    rf_we_i = 1'b0;
    #1;
    checkOutput("rf next-cycle rs1", 64'(rs1_o), 64'hDEAD_BEEF);
    rf_we_i = 1'b1; rf_rd_i = 5'd0; rf_wdata_i = 32'h1234_5678; rs1_i = 5'd0; rs2_i = 5'd5;
    @(posedge clk);
    #1;
    rf_we_i = 1'b0;
    #1;
    checkOutput("rf x0 rs1", 64'(rs1_o), 64'h0);
    checkOutput("rf x5 rs2", 64'(rs2_o), 64'hDEAD_BEEF);
    rf_we_i = 1'b1; rf_rd_i = 5'd5; rf_wdata_i = 32'h0000_0001; rs1_i = 5'd5;
    #1;
    checkOutput("rf overwrite old", 64'(rs1_o), 64'hDEAD_BEEF);
    @(posedge clk);
    #1;
    rf_we_i = 1'b0;
    #1;
    checkOutput("rf overwrite new", 64'(rs1_o), 64'h1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
